// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection (jr > jump > branch > sequential),
// stall support and fetch counter. Define MISALIGN_TRAP_EN to trap misaligned targets.
module pc_unit #(
    parameter int             N            = 32,
    parameter int             STEP         = 4,
    parameter logic [N-1:0]   RESET_VECTOR = N'(32'h0000_0000),
    parameter logic [N-1:0]   EXC_VECTOR   = N'(32'h0000_0080),
    parameter int             CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jr,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    input  logic [N-1:0]     jr_target,
    output logic [N-1:0]     pc,
    output logic [N-1:0]     pc_plus_step,
    output logic [N-1:0]     pc_next,
    output logic             redirect,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             misalign_trap,
    output logic [N-1:0]     epc
);

    localparam logic [N-1:0] STEP_N = N'(STEP);

    logic [N-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect_q, redirect_d;
    logic [N-1:0]     pc_plus_step_s;
    logic [N-1:0]     br_off_s;
    logic [N-1:0]     br_tgt_s;
    logic [N-1:0]     jmp_tgt_s;
    logic [N-1:0]     pc_next_s;
    logic             nonseq_s;

    // The jump region bits only exist when the address is wider than the 28-bit jump span.
    if (N < 28 || EXC_VECTOR[1:0] != 2'b00) begin : g_param_check
        $error("pc_unit: N must be >= 28 and EXC_VECTOR word aligned");
    end

    if (N > 28) begin : g_jmp_wide
        assign jmp_tgt_s = {pc_plus_step_s[N-1:28], jaddr, 2'b00};
    end else begin : g_jmp_narrow
        assign jmp_tgt_s = {jaddr, 2'b00};
    end

    assign pc_plus_step_s = pc_q + STEP_N;
    assign br_off_s       = {{(N-18){imm16[15]}}, imm16, 2'b00};
    assign br_tgt_s       = pc_plus_step_s + br_off_s;
    assign nonseq_s       = jr | jump | branch_taken;

    // Fixed-priority target selection.
    always_comb begin
        pc_next_s = pc_plus_step_s;
        if (jr) begin
            pc_next_s = jr_target;
        end else if (jump) begin
            pc_next_s = jmp_tgt_s;
        end else if (branch_taken) begin
            pc_next_s = br_tgt_s;
        end else begin
            pc_next_s = pc_plus_step_s;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic             trap_q, trap_d;
    logic [N-1:0]     epc_q, epc_d;

    // Next-state logic; a misaligned target diverts to the exception vector.
    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        trap_d     = 1'b0;
        epc_d      = epc_q;
        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (pc_next_s[1:0] != 2'b00) begin
                pc_d       = EXC_VECTOR;
                epc_d      = pc_next_s;
                trap_d     = 1'b1;
                redirect_d = 1'b1;
            end else begin
                pc_d       = pc_next_s;
                redirect_d = nonseq_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Trap state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            epc_q  <= {N{1'b0}};
        end else begin
            trap_q <= trap_d;
            epc_q  <= epc_d;
        end
    end

    assign misalign_trap = trap_q;
    assign epc           = epc_q;
`else
    // Next-state logic; targets are loaded as computed.
    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        if (en) begin
            cnt_d      = cnt_q + CNT_W'(1);
            pc_d       = pc_next_s;
            redirect_d = nonseq_s;
        end else begin
            pc_d = pc_q;
        end
    end

    assign misalign_trap = 1'b0;
    assign epc           = {N{1'b0}};
`endif

    // PC, fetch counter and redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            cnt_q      <= {CNT_W{1'b0}};
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_step = pc_plus_step_s;
    assign pc_next      = pc_next_s;
    assign redirect     = redirect_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected state, a monitor compares after each edge.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] fetch_cnt;
    logic        misalign_trap;
    logic [31:0] epc;
    logic        probe;

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_ON = 1'b1;
`else
    localparam logic TRAP_ON = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] nxt;
        logic        rd;
        logic [31:0] cnt;
        logic        trap;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .imm16        (imm16),
        .jaddr        (jaddr),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus_step (pc_plus_step),
        .pc_next      (pc_next),
        .redirect     (redirect),
        .fetch_cnt    (fetch_cnt),
        .misalign_trap(misalign_trap),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
        end
    endtask

    // Monitor: after every clock edge or asynchronous probe, pop and compare one expectation.
    always @(posedge clk or posedge probe) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "pc",        pc,                  e.pc);
            chk(e.nm, "pc_next",   pc_next,             e.nxt);
            chk(e.nm, "pc_plus",   pc_plus_step,        e.pc + 32'd4);
            chk(e.nm, "redirect",  {31'd0, redirect},   {31'd0, e.rd});
            chk(e.nm, "fetch_cnt", fetch_cnt,           e.cnt);
            chk(e.nm, "trap",      {31'd0, misalign_trap}, {31'd0, e.trap});
            chk(e.nm, "epc",       epc,                 e.epc);
        end
    end

    task automatic push(input string nm, input logic [31:0] x_pc, input logic [31:0] x_nxt,
                        input logic x_rd, input logic [31:0] x_cnt, input logic x_trap,
                        input logic [31:0] x_epc);
        exp_t e;
        e.nm = nm; e.pc = x_pc; e.nxt = x_nxt; e.rd = x_rd;
        e.cnt = x_cnt; e.trap = x_trap; e.epc = x_epc;
        exp_q.push_back(e);
    endtask

    // One clock: drive at negedge, queue the state expected after the following rising edge.
    task automatic cyc(input string nm, input logic e, input logic b, input logic j, input logic r,
                       input logic [15:0] im, input logic [25:0] ja, input logic [31:0] jt,
                       input logic [31:0] x_pc, input logic [31:0] x_nxt, input logic x_rd,
                       input logic [31:0] x_cnt, input logic x_trap, input logic [31:0] x_epc);
        en = e; branch_taken = b; jump = j; jr = r;
        imm16 = im; jaddr = ja; jr_target = jt;
        push(nm, x_pc, x_nxt, x_rd, x_cnt, x_trap, x_epc);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] epc_keep;
        rst_n = 1'b0; probe = 1'b0;
        en = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        imm16 = 16'h0000; jaddr = 26'h0; jr_target = 32'h0;
        @(negedge clk);
        cyc("reset",  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0, 32'h4, 1'b0, 32'd0, 1'b0, 32'h0);
        rst_n = 1'b1;
        cyc("seq1",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h4, 32'h8,  1'b0, 32'd1, 1'b0, 32'h0);
        cyc("seq2",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h8, 32'hC,  1'b0, 32'd2, 1'b0, 32'h0);
        cyc("seq3",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'hC, 32'h10, 1'b0, 32'd3, 1'b0, 32'h0);
        cyc("jr100",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h100, 32'h100, 32'h100, 1'b1, 32'd4, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++)
            cyc("stall", 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h100, 32'hFC, 1'b0, 32'd4, 1'b0, 32'h0);
        cyc("brneg",  1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'hFC, 32'hF8, 1'b1, 32'd5, 1'b0, 32'h0);
        cyc("seq4",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h100, 32'h104, 1'b0, 32'd6, 1'b0, 32'h0);
        cyc("jrhi",   1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 1'b1, 32'd7, 1'b0, 32'h0);
        cyc("jmphi",  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h40, 32'h0, 32'h1000_0100, 32'h1000_0100, 1'b1, 32'd8, 1'b0, 32'h0);
        cyc("jrhi2",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 1'b1, 32'd9, 1'b0, 32'h0);
        cyc("jrwin",  1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 26'h40, 32'h0040_0020, 32'h0040_0020, 32'h0040_0020, 1'b1, 32'd10, 1'b0, 32'h0);
        cyc("jmpwin", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 26'h1000, 32'h0, 32'h4000, 32'h4000, 1'b1, 32'd11, 1'b0, 32'h0);
        cyc("jrtop",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd12, 1'b0, 32'h0);
        cyc("wrap",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0, 32'h4, 1'b0, 32'd13, 1'b0, 32'h0);
        cyc("brwrap", 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1, 32'd14, 1'b0, 32'h0);
        epc_keep = TRAP_ON ? 32'h102 : 32'h0;
        cyc("misal",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h102,
            TRAP_ON ? 32'h80 : 32'h102, 32'h102, 1'b1, 32'd15, TRAP_ON, epc_keep);
        cyc("mstall", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,
            TRAP_ON ? 32'h80 : 32'h102, TRAP_ON ? 32'h84 : 32'h106, 1'b0, 32'd15, 1'b0, epc_keep);
        cyc("jr200",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h200, 32'h200, 32'h200, 1'b1, 32'd16, 1'b0, epc_keep);
        #1;
        en = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
        rst_n = 1'b0;
        push("async_rst", 32'h0, 32'h4, 1'b0, 32'd0, 1'b0, 32'h0);
        probe = 1'b1;
        #1 probe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h4, 32'h8, 1'b0, 32'd1, 1'b0, 32'h0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout time=%0t limit=50000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the single-cycle MIPS core.
- Holds the PC register and computes the sequential increment, branch target, jump target and jump-register target internally.
- Selects and registers the next PC every cycle, with stall support and a cumulative fetch counter.
- Replaces the standalone PC+4 adder and the separate next-PC muxing in the datapath.

Parameters:
- N, 32, PC/address width; N >= 28 required.
- STEP, 4, sequential increment in bytes.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (N bits).
- EXC_VECTOR, 32'h0000_0080, trap target (used only with MISALIGN_TRAP_EN).
- CNT_W, 32, fetch counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  PC update enable; 0 = stall, hold all state
- branch_taken  in  1  conditional branch resolved taken
- jump  in  1  J/JAL
- jr  in  1  JR/JALR
- imm16  in  16  branch offset in words, signed
- jaddr  in  26  jump index field
- jr_target  in  N  register-file jump target
- pc  out  N  current PC (registered)
- pc_plus_step  out  N  pc + STEP (combinational)
- pc_next  out  N  value to be loaded at the next enabled edge (combinational)
- redirect  out  1  registered; 1 for one cycle after a non-sequential load
- fetch_cnt  out  CNT_W  number of enabled PC updates since reset
- misalign_trap  out  1  registered trap pulse (0 when feature off)
- epc  out  N  offending target (0 when feature off)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (rst_n=0, async):
  - pc = RESET_VECTOR.
  - redirect = 0, fetch_cnt = 0, misalign_trap = 0, epc = 0.
  - Reset mid-stall or mid-redirect overrides everything; the first enabled edge after release loads pc_next computed from RESET_VECTOR.
- Arithmetic (modulo 2^N, wrap-around silent):
  - pc_plus_step = pc + STEP.
  - branch target = pc_plus_step + (sign_extend(imm16) << 2).
  - jump target = {pc_plus_step[N-1:28], jaddr, 2'b00}.
  - jr target = jr_target.
- Selection priority, fixed: jr > jump > branch_taken > sequential. Multiple asserted selects are legal and resolve by priority.
- pc_next reflects the selection combinationally, independent of en.
- On a rising clk with en=1:
  - pc <= pc_next.
  - fetch_cnt <= fetch_cnt + 1, wrapping at 2^CNT_W.
  - redirect <= (jr | jump | branch_taken).
- On a rising clk with en=0:
  - pc and fetch_cnt hold.
  - redirect <= 0.
  - Select inputs are ignored for state, but pc_next still reflects them.
- Latency:
  - pc_plus_step and pc_next: 0 cycles (combinational).
  - pc: 1 cycle.
  - redirect and misalign_trap: 1 cycle after the load edge.
- Wrap-around:
  - pc = {N{1'b1}} - 3 with STEP=4 → next pc = 0.
  - Negative branch offsets below address 0 wrap modulo 2^N.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On an enabled edge where pc_next[1:0] != 0, pc <= EXC_VECTOR instead of pc_next.
  - epc <= pc_next (the misaligned target).
  - misalign_trap <= 1 for exactly one cycle; redirect <= 1.
  - fetch_cnt increments normally.
  - A stall holds epc and forces misalign_trap to 0.
- Undefined:
  - The misaligned target is loaded unchanged.
  - misalign_trap and epc are tied to 0.
  - Ports remain present in both builds.

Test Plan:
- Reset then 3 enabled cycles, no selects → pc 0x0 → 0x4 → 0x8 → 0xC; fetch_cnt = 3; redirect stays 0.
- pc=0x100, branch_taken=1, imm16=0xFFFE → pc_next = 0x0FC; next pc = 0x0FC; redirect = 1 for one cycle.
- pc=0x1000_0000, jump=1, jaddr=0x0000040, plus jr=1, jr_target=0x0040_0020 asserted together → pc = 0x0040_0020 (jr wins).
- en=0 for 4 cycles with branch_taken=1 → pc and fetch_cnt unchanged; pc_next still shows the branch target; redirect = 0.
- pc=0xFFFF_FFFC, sequential step → pc = 0x0; rst_n pulsed low asynchronously mid-cycle → pc = RESET_VECTOR immediately, fetch_cnt = 0.
- MISALIGN_TRAP_EN defined, jr=1, jr_target=0x0000_0102 → pc = 0x80; epc = 0x102; misalign_trap = 1 for one cycle.
- Same stimulus with MISALIGN_TRAP_EN undefined → pc = 0x102; misalign_trap = 0.
